hero_write_rx: RTL and testbench

Receive end of the hero write bus. The block samples one `hero_write_t` beat per cycle, frames IDLE/VALID/DONE sequences into transactions and buffers the beats in a FIFO. It presents the beats to the consumer on a valid/ready stream with last/err markers. The hero bus has no backpressure, so the block detects and reports overflow, over-length and illegal encodings, and always closes a corrupted transaction with an error terminator.

---
 rtl/hero_write_rx_pkg.sv | 36 +++
 rtl/hero_rx_fifo.sv | 61 ++++++
 rtl/hero_write_rx.sv | 133 +++++++++++++
 tb/tb_hero_write_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hero_write_rx_pkg.sv
// Shared types for the hero write bus receiver: bus beat format, cycle
// encodings, framing states and the buffered entry layout.
package hero_write_rx_pkg;

  localparam int HERO_WIDTH = 36;

  typedef enum logic [3:0] {
    CT_IDLE  = 4'd0,
    CT_VALID = 4'd1,
    CT_DONE  = 4'd2
  } CYCLE_TYPE_E;

  typedef struct packed {
    logic [3:0]            cycle_type;
    logic [HERO_WIDTH-1:0] wdat;
    logic                  clk_en;
  } hero_write_t;

  typedef enum logic [1:0] {
    IDLE_S,
    XFER_S,
    DROP_S
  } hero_rx_state_e;

  typedef struct packed {
    logic                  err;
    logic                  last;
    logic [HERO_WIDTH-1:0] data;
  } hero_rx_entry_t;

  // Encodings above DONE are reserved and must be flagged by the receiver.
  function automatic logic is_legal_ct(input logic [3:0] ct);
    return (ct <= 4'(CT_DONE));
  endfunction

endpackage

// File: rtl/hero_rx_fifo.sv
// Entry FIFO for the hero receiver. Level is kept beside the pointers so
// full/empty never alias; the head reads as all-zero while empty.
module hero_rx_fifo
  import hero_write_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  hero_rx_entry_t             push_entry,
  input  logic                       pop,
  output hero_rx_entry_t             head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);

  hero_rx_entry_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (level_q != '0);
  assign do_push = push && ((level_q != LVL_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
    else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_valid = (level_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;

endmodule

// File: rtl/hero_write_rx.sv
// Receive end of the hero write bus: frames beats into transactions, buffers
// them, and closes any transaction that lost beats with an error terminator.
module hero_write_rx
  import hero_write_rx_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  hero_write_t                hero_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [HERO_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic                       out_err,
  output logic                       err_overflow,
  output logic                       err_length,
  output logic                       err_illegal,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS+1) : 1;

  hero_rx_state_e   state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             term_pend_q, term_pend_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_length_q, err_length_d;
  logic             err_illegal_q, err_illegal_d;

  logic             push, pop, space;
  hero_rx_entry_t   push_entry, head;
  logic             head_valid;
  logic [LVL_W-1:0] level;
  logic             legal, is_valid, is_done, is_beat;
  logic             fail_len, fail_any;

  assign pop      = head_valid && out_ready;
  assign space    = (level != LVL_W'(DEPTH)) || pop;
  assign legal    = is_legal_ct(hero_in.cycle_type);
  assign is_valid = hero_in.clk_en && (hero_in.cycle_type == 4'(CT_VALID));
  assign is_done  = hero_in.clk_en && (hero_in.cycle_type == 4'(CT_DONE));
  assign is_beat  = is_valid || is_done;

  // Length only bites inside a transaction; a first beat is always number 1.
  assign fail_len = (state_q == XFER_S) && (beat_cnt_q == CNT_W'(MAX_BEATS));
  assign fail_any = fail_len || term_pend_q || !space;

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    term_pend_d    = term_pend_q;
    push           = 1'b0;
    push_entry     = '0;
    err_overflow_d = 1'b0;
    err_length_d   = 1'b0;
    err_illegal_d  = hero_in.clk_en && !legal;

    if (term_pend_q && space) begin
      push        = 1'b1;
      push_entry  = '{err: 1'b1, last: 1'b1, data: '0};
      term_pend_d = 1'b0;
    end

    if (is_beat) begin
      if (state_q == DROP_S) begin
        if (is_done) begin
          state_d    = IDLE_S;
          beat_cnt_d = '0;
        end
      end else if (fail_any) begin
        if (fail_len) err_length_d   = 1'b1;
        else          err_overflow_d = 1'b1;
        if (state_q == XFER_S) term_pend_d = 1'b1;
        state_d    = is_valid ? DROP_S : IDLE_S;
        beat_cnt_d = '0;
      end else begin
        push       = 1'b1;
        push_entry = '{err: 1'b0, last: is_done, data: hero_in.wdat};
        if (is_done) begin
          state_d    = IDLE_S;
          beat_cnt_d = '0;
        end else begin
          state_d    = XFER_S;
          beat_cnt_d = (state_q == IDLE_S) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE_S;
      beat_cnt_q     <= '0;
      term_pend_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_length_q   <= 1'b0;
      err_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      term_pend_q    <= term_pend_d;
      err_overflow_q <= err_overflow_d;
      err_length_q   <= err_length_d;
      err_illegal_q  <= err_illegal_d;
    end
  end

  hero_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .level      (level)
  );

  assign out_valid    = head_valid;
  assign out_data     = head.data;
  assign out_last     = head.last;
  assign out_err      = head.err;
  assign err_overflow = err_overflow_q;
  assign err_length   = err_length_q;
  assign err_illegal  = err_illegal_q;
  assign fifo_level   = level;

endmodule

// File: tb/tb_hero_write_rx.sv
// Directed bench for hero_write_rx: a default instance (DEPTH 8, MAX_BEATS 16)
// and a short-length instance (MAX_BEATS 4), each checked against a queue.
module tb_hero_write_rx;
  import hero_write_rx_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hero_write_t          hin_a, hin_b;
  logic                 rdy_a, rdy_b;
  logic                 vld_a, vld_b, last_a, last_b, erre_a, erre_b;
  logic [HERO_WIDTH-1:0] data_a, data_b;
  logic                 ovf_a, ovf_b, len_a, len_b, ill_a, ill_b;
  logic [3:0]           lvl_a, lvl_b;

  hero_write_rx #(.DEPTH(8), .MAX_BEATS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hero_in(hin_a),
    .out_valid(vld_a), .out_ready(rdy_a), .out_data(data_a),
    .out_last(last_a), .out_err(erre_a),
    .err_overflow(ovf_a), .err_length(len_a), .err_illegal(ill_a),
    .fifo_level(lvl_a)
  );

  hero_write_rx #(.DEPTH(8), .MAX_BEATS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .hero_in(hin_b),
    .out_valid(vld_b), .out_ready(rdy_b), .out_data(data_b),
    .out_last(last_b), .out_err(erre_b),
    .err_overflow(ovf_b), .err_length(len_b), .err_illegal(ill_b),
    .fifo_level(lvl_b)
  );

  int checks = 0;
  int errors = 0;
  logic [37:0] sb_a[$];
  logic [37:0] sb_b[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic [3:0] ct, input logic [35:0] d, input logic en);
    hin_a.cycle_type = ct;
    hin_a.wdat       = d;
    hin_a.clk_en     = en;
  endtask

  task automatic drv_b(input logic [3:0] ct, input logic [35:0] d, input logic en);
    hin_b.cycle_type = ct;
    hin_b.wdat       = d;
    hin_b.clk_en     = en;
  endtask

  task automatic mon();
    logic [37:0] e;
    if (vld_a && rdy_a) begin
      if (sb_a.size() == 0) chk("a_unexpected_entry", 64'(sb_a.size()), 64'd1);
      else begin
        e = sb_a.pop_front();
        chk("a_entry", {26'd0, erre_a, last_a, data_a}, {26'd0, e});
      end
    end
    if (vld_b && rdy_b) begin
      if (sb_b.size() == 0) chk("b_unexpected_entry", 64'(sb_b.size()), 64'd1);
      else begin
        e = sb_b.pop_front();
        chk("b_entry", {26'd0, erre_b, last_b, data_b}, {26'd0, e});
      end
    end
  endtask

  // One bus cycle: sample at the falling edge, then return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drv_a(4'(CT_IDLE), '0, 1'b0);
    drv_b(4'(CT_IDLE), '0, 1'b0);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {vld_a, data_a, last_a, erre_a, ovf_a, len_a, ill_a, lvl_a}, '0);
    chk({tag, "_b"}, {vld_b, data_b, last_b, erre_b, ovf_b, len_b, ill_b, lvl_b}, '0);
  endtask

  initial begin
    logic [35:0] d;
    rst_n = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    drv_a(4'(CT_IDLE), '0, 1'b0);
    drv_b(4'(CT_IDLE), '0, 1'b0);
    #1;
    chk_zero("reset");
    cyc();
    cyc();
    rst_n = 1'b1;
    idle(2);

    // Three-beat transaction streamed straight through
    drv_a(4'(CT_VALID), 36'hA, 1'b1); sb_a.push_back({2'b00, 36'hA}); cyc();
    chk("t1_ovf", ovf_a, 0);
    drv_a(4'(CT_VALID), 36'hB, 1'b1); sb_a.push_back({2'b00, 36'hB}); cyc();
    drv_a(4'(CT_DONE),  36'hC, 1'b1); sb_a.push_back({2'b01, 36'hC}); cyc();
    chk("t1_errs", {ovf_a, len_a, ill_a}, 0);
    idle(3);
    chk("t1_level", lvl_a, 0);

    // Single-beat DONE from idle, then a VALID without clk_en
    drv_a(4'(CT_DONE), 36'h5, 1'b1); sb_a.push_back({2'b01, 36'h5}); cyc();
    drv_a(4'(CT_VALID), 36'h6, 1'b0); cyc();
    idle(3);
    chk("t2_level", lvl_a, 0);

    // Ten beats into an eight-deep FIFO with the consumer stalled
    rdy_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = 36'h100 + 36'(i);
      drv_a((i == 9) ? 4'(CT_DONE) : 4'(CT_VALID), d, 1'b1);
      if (i < 8) sb_a.push_back({2'b00, d});
      cyc();
      if (i < 9) chk($sformatf("t3_ovf_beat%0d", i + 1), ovf_a, (i == 8));
    end
    sb_a.push_back({2'b11, 36'h0});
    idle(1);
    chk("t3_level_full", lvl_a, 8);
    rdy_a = 1'b1;
    idle(12);
    chk("t3_level_drained", lvl_a, 0);

    // Over-length transaction on the MAX_BEATS=4 instance, then a clean one
    for (int i = 0; i < 6; i++) begin
      d = 36'h300 + 36'(i);
      drv_b((i == 5) ? 4'(CT_DONE) : 4'(CT_VALID), d, 1'b1);
      if (i < 4) sb_b.push_back({2'b00, d});
      cyc();
      chk($sformatf("t4_len_beat%0d", i + 1), len_b, (i == 4));
    end
    sb_b.push_back({2'b11, 36'h0});
    chk("t4_no_ovf", ovf_b, 0);
    drv_b(4'(CT_VALID), 36'h377, 1'b1); sb_b.push_back({2'b00, 36'h377}); cyc();
    drv_b(4'(CT_DONE),  36'h378, 1'b1); sb_b.push_back({2'b01, 36'h378}); cyc();
    chk("t4_next_errs", {ovf_b, len_b, ill_b}, 0);
    idle(4);

    // Illegal encoding inside a transaction
    drv_a(4'(CT_VALID), 36'h11, 1'b1); sb_a.push_back({2'b00, 36'h11}); cyc();
    drv_a(4'd7, 36'hEE, 1'b1); cyc();
    chk("t5_illegal", ill_a, 1);
    drv_a(4'(CT_DONE), 36'h12, 1'b1); sb_a.push_back({2'b01, 36'h12}); cyc();
    chk("t5_illegal_clear", {ovf_a, len_a, ill_a}, 0);
    idle(3);

    // Full FIFO with simultaneous push and pop, then reset mid-transaction
    rdy_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 36'h200 + 36'(i);
      drv_a(4'(CT_VALID), d, 1'b1);
      sb_a.push_back({2'b00, d});
      cyc();
    end
    chk("t6_level_full", lvl_a, 8);
    rdy_a = 1'b1;
    drv_a(4'(CT_VALID), 36'h208, 1'b1); sb_a.push_back({2'b00, 36'h208}); cyc();
    chk("t6_level_pushpop", lvl_a, 8);
    chk("t6_no_ovf", ovf_a, 0);
    rdy_a = 1'b0;
    drv_a(4'(CT_IDLE), '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_reset");
    sb_a.delete();
    cyc();
    rst_n = 1'b1;
    rdy_a = 1'b1;
    idle(1);
    drv_a(4'(CT_VALID), 36'h21, 1'b1); sb_a.push_back({2'b00, 36'h21}); cyc();
    drv_a(4'(CT_DONE),  36'h22, 1'b1); sb_a.push_back({2'b01, 36'h22}); cyc();
    idle(4);
    chk("t6_level_end", lvl_a, 0);

    chk("sb_a_drained", 64'(sb_a.size()), 0);
    chk("sb_b_drained", 64'(sb_b.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
